xor_share_arb: RTL

Round-robin arbiter and sequencer that shares one registered W-bit XOR datapath between N requesters. Each requester presents two operands and a request; the block grants one requester at a time, computes A^B, and holds the result on a single output port under a valid/ready handshake. It sits between the lab's requester front-ends (switch/UART command decoders) and the shared result sink (display or TX path).

---
 rtl/xor_arb_pkg.sv | 14 +
 rtl/xor_share_arb_if.sv | 28 ++
 rtl/xor_share_arb_rr_pick.sv | 37 +++
 rtl/xor_share_arb.sv | 67 ++++++
 4 files changed

// File: rtl/xor_arb_pkg.sv
// Shared types and helpers for the round-robin XOR sharing arbiter.
package xor_arb_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } state_e;

    // Requester-id width; a single-bit id is kept even for degenerate N.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xor_share_arb_if.sv
// Requester/sink bundle: N requesters in, one result port out.
interface xor_share_arb_if
    import xor_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int IDW = idw(N);

    logic [N-1:0]   req;
    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] b_flat;
    logic [N-1:0]   gnt;
    logic [W-1:0]   r;
    logic [IDW-1:0] r_id;
    logic           r_valid;
    logic           r_ready;

    modport master (
        output req, a_flat, b_flat, r_ready,
        input  gnt, r, r_id, r_valid
    );

    modport slave (
        input  req, a_flat, b_flat, r_ready,
        output gnt, r, r_id, r_valid
    );
endinterface

// File: rtl/xor_share_arb_rr_pick.sv
// Round-robin winner select: rotate so (last_id+1) sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick
    import xor_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = idw(N)
) (
    input  logic [N-1:0]   req_eff,
    input  logic [IDW-1:0] last_id,
    output logic           any,
    output logic [IDW-1:0] win,
    output logic [N-1:0]   win_onehot
);
    logic [IDW-1:0] start;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDW-1:0] pos;
    logic [IDW:0]   sum;

    // N need not be a power of two, so the wrap is explicit.
    assign start = (int'(last_id) >= N - 1) ? '0 : last_id + IDW'(1);
    assign dbl   = {req_eff, req_eff} >> start;
    assign rot   = dbl[N-1:0];
    assign any   = |req_eff;

    always_comb begin
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) pos = IDW'(k);
        end
    end

    assign sum        = {1'b0, start} + {1'b0, pos};
    assign win        = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : sum[IDW-1:0];
    assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win;
endmodule

// File: rtl/xor_share_arb.sv
// One shared registered XOR datapath, granted round-robin to N requesters,
// with the result held under a valid/ready handshake.
module xor_share_arb
    import xor_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset_p,
    xor_share_arb_if.slave bus
);
    localparam int IDW = idw(N);

    state_e         state_q;
    logic [N-1:0]   gnt_q;
    logic [W-1:0]   r_q;
    logic [IDW-1:0] r_id_q;
    logic [IDW-1:0] last_q;

    logic [N-1:0]   req_eff;
    logic [N-1:0]   win_oh;
    logic [IDW-1:0] win;
    logic           any;
    logic           cap;
    logic [W-1:0]   r_d;

    // A requester granted this cycle cannot be picked again until next cycle.
    assign req_eff = bus.req & ~gnt_q;

    rr_pick #(.N(N)) u_pick (
        .req_eff    (req_eff),
        .last_id    (last_q),
        .any        (any),
        .win        (win),
        .win_onehot (win_oh)
    );

    assign r_d = bus.a_flat[win*W +: W] ^ bus.b_flat[win*W +: W];
    assign cap = ((state_q == S_IDLE) || bus.r_ready) && any;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            r_q     <= '0;
            r_id_q  <= '0;
            last_q  <= IDW'(N - 1);
        end else begin
            gnt_q <= '0;
            if (cap) begin
                r_q     <= r_d;
                r_id_q  <= win;
                last_q  <= win;
                gnt_q   <= win_oh;
                state_q <= S_VALID;
            end else if (state_q == S_VALID && bus.r_ready) begin
                state_q <= S_IDLE;
            end
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.r       = r_q;
    assign bus.r_id    = r_id_q;
    assign bus.r_valid = (state_q == S_VALID);
endmodule
